// File: rtl/adder_seg_unit_if.sv
// rtl/adder_seg_unit_if.sv - adder callee handshake between FPU adder controller and segmented adder
interface adder_seg_unit_if;
  logic        Adder_valid;
  logic [24:0] Adder_datain1;
  logic [24:0] Adder_datain2;
  logic [24:0] Adder_dataout;
  logic        Adder_carryout;
  logic [1:0]  Adder_Exc;
  logic        Adder_ack;
  logic        Busy;

  modport master (
    output Adder_valid,
    output Adder_datain1,
    output Adder_datain2,
    input  Adder_dataout,
    input  Adder_carryout,
    input  Adder_Exc,
    input  Adder_ack,
    input  Busy
  );

  modport slave (
    input  Adder_valid,
    input  Adder_datain1,
    input  Adder_datain2,
    output Adder_dataout,
    output Adder_carryout,
    output Adder_Exc,
    output Adder_ack,
    output Busy
  );
endinterface

// File: rtl/adder_seg_unit.sv
// rtl/adder_seg_unit.sv - segmented multi-cycle 25-bit adder responding on the adder handshake
module adder_seg_unit #(
  parameter int SEG_W = 5
) (
  input  logic CLK,
  input  logic RSTn,
  adder_seg_unit_if.slave bus
);

  localparam int N_SEG = 25 / SEG_W;
  localparam int CNT_W = (N_SEG > 1) ? $clog2(N_SEG) : 1;
  localparam logic [CNT_W-1:0] LAST_SEG = CNT_W'(N_SEG - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ADD      = 2'd1;
  localparam logic [1:0] ST_DONE     = 2'd2;
  localparam logic [1:0] ST_WAIT_REL = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [24:0]      a_q, a_d;
  logic [24:0]      b_q, b_d;
  logic [24:0]      sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cin_q, cin_d;
  logic [24:0]      dout_q, dout_d;
  logic             cout_q, cout_d;
  logic [1:0]       exc_q, exc_d;
  logic             ack_q, ack_d;
  logic             busy_q, busy_d;

  logic [SEG_W-1:0] seg_a, seg_b;
  logic [SEG_W:0]   seg_sum;

  // One segment of the carry chain, selected by the segment counter
  always_comb begin
    seg_a   = a_q[int'(cnt_q) * SEG_W +: SEG_W];
    seg_b   = b_q[int'(cnt_q) * SEG_W +: SEG_W];
    seg_sum = {1'b0, seg_a} + {1'b0, seg_b} + {{SEG_W{1'b0}}, cin_q};
  end

  // Handshake state machine; results only change when DONE is entered
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    cin_d   = cin_q;
    dout_d  = dout_q;
    cout_d  = cout_q;
    exc_d   = exc_q;
    ack_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.Adder_valid) begin
          if (bus.Adder_datain1[24]) begin
            // Operand 1 must be a non-negative mantissa; reject without adding
            dout_d  = '0;
            cout_d  = 1'b0;
            exc_d   = 2'b01;
            ack_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            a_d     = bus.Adder_datain1;
            b_d     = bus.Adder_datain2;
            sum_d   = '0;
            cnt_d   = '0;
            cin_d   = 1'b0;
            state_d = ST_ADD;
          end
        end
      end

      ST_ADD: begin
        if (!bus.Adder_valid) begin
          // Caller withdrew the request: drop it silently, keep old results
          state_d = ST_IDLE;
          cnt_d   = '0;
          cin_d   = 1'b0;
        end else begin
          sum_d[int'(cnt_q) * SEG_W +: SEG_W] = seg_sum[SEG_W-1:0];
          cin_d = seg_sum[SEG_W];
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == LAST_SEG) begin
            dout_d  = sum_d;
            cout_d  = seg_sum[SEG_W];
            exc_d   = 2'b00;
            ack_d   = 1'b1;
            cnt_d   = '0;
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        state_d = bus.Adder_valid ? ST_WAIT_REL : ST_IDLE;
      end

      ST_WAIT_REL: begin
        // A valid still held from the finished request is not a new request
        if (!bus.Adder_valid) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and result registers, synchronous active-low reset wins over everything
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      cin_q   <= 1'b0;
      dout_q  <= '0;
      cout_q  <= 1'b0;
      exc_q   <= 2'b00;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      cin_q   <= cin_d;
      dout_q  <= dout_d;
      cout_q  <= cout_d;
      exc_q   <= exc_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.Adder_dataout  = dout_q;
  assign bus.Adder_carryout = cout_q;
  assign bus.Adder_Exc      = exc_q;
  assign bus.Adder_ack      = ack_q;
  assign bus.Busy           = busy_q;

endmodule

// File: tb/tb_adder_seg_unit.sv
// tb/tb_adder_seg_unit.sv - self-checking bench for adder_seg_unit at SEG_W 5, 1 and 25
module tb_adder_seg_unit;

  logic CLK = 1'b0;
  logic RSTn;
  always #5 CLK = ~CLK;

  logic [2:0]  valid;
  logic [24:0] din1, din2;

  adder_seg_unit_if if5 ();
  adder_seg_unit_if if1 ();
  adder_seg_unit_if if25 ();

  assign if5.Adder_valid    = valid[0];
  assign if5.Adder_datain1  = din1;
  assign if5.Adder_datain2  = din2;
  assign if1.Adder_valid    = valid[1];
  assign if1.Adder_datain1  = din1;
  assign if1.Adder_datain2  = din2;
  assign if25.Adder_valid   = valid[2];
  assign if25.Adder_datain1 = din1;
  assign if25.Adder_datain2 = din2;

  adder_seg_unit #(.SEG_W(5))  dut5  (.CLK(CLK), .RSTn(RSTn), .bus(if5.slave));
  adder_seg_unit #(.SEG_W(1))  dut1  (.CLK(CLK), .RSTn(RSTn), .bus(if1.slave));
  adder_seg_unit #(.SEG_W(25)) dut25 (.CLK(CLK), .RSTn(RSTn), .bus(if25.slave));

  logic [24:0] dout_w [3];
  logic        cout_w [3];
  logic [1:0]  exc_w  [3];
  logic        ack_w  [3];
  logic        busy_w [3];

  assign dout_w[0] = if5.Adder_dataout;
  assign dout_w[1] = if1.Adder_dataout;
  assign dout_w[2] = if25.Adder_dataout;
  assign cout_w[0] = if5.Adder_carryout;
  assign cout_w[1] = if1.Adder_carryout;
  assign cout_w[2] = if25.Adder_carryout;
  assign exc_w[0]  = if5.Adder_Exc;
  assign exc_w[1]  = if1.Adder_Exc;
  assign exc_w[2]  = if25.Adder_Exc;
  assign ack_w[0]  = if5.Adder_ack;
  assign ack_w[1]  = if1.Adder_ack;
  assign ack_w[2]  = if25.Adder_ack;
  assign busy_w[0] = if5.Busy;
  assign busy_w[1] = if1.Busy;
  assign busy_w[2] = if25.Busy;

  int n_checks = 0;
  int n_errors = 0;
  int ack_double = 0;
  logic [2:0] ack_prev = 3'b000;

  // Ack must never be high in two consecutive cycles on any instance
  always @(posedge CLK) begin
    for (int i = 0; i < 3; i++) begin
      if (ack_w[i] && ack_prev[i]) ack_double <= ack_double + 1;
    end
    ack_prev <= {ack_w[2], ack_w[1], ack_w[0]};
  end

  typedef struct {
    logic [24:0] a;
    logic [24:0] b;
    logic [24:0] exp_d;
    logic        exp_c;
    logic [1:0]  exp_e;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int seg_of(input int w);
    case (w)
      0:       return 5;
      1:       return 1;
      default: return 25;
    endcase
  endfunction

  // Reference: exact 26-bit sum, or a rejection for negative operand 1
  function automatic logic [27:0] ref_model(input logic [24:0] a, input logic [24:0] b);
    logic [25:0] s;
    if (a[24]) return {2'b01, 1'b0, 25'd0};
    s = {1'b0, a} + {1'b0, b};
    return {2'b00, s};
  endfunction

  function automatic int ref_latency(input int w, input logic [24:0] a);
    if (a[24]) return 1;
    return 25 / seg_of(w) + 1;
  endfunction

  task automatic run_op(input int w, input logic [24:0] a, input logic [24:0] b,
                        input bit scramble, output int lat, output logic [24:0] d,
                        output logic c, output logic [1:0] e, output logic busy_after);
    bit got;
    got = 0;
    d = '0; c = 1'b0; e = 2'b00;
    @(negedge CLK);
    din1 = a;
    din2 = b;
    valid[w] = 1'b1;
    lat = 0;
    while (!got && lat < 80) begin
      @(posedge CLK);
      #1;
      lat++;
      if (ack_w[w]) begin
        got = 1;
        d = dout_w[w];
        c = cout_w[w];
        e = exc_w[w];
        valid[w] = 1'b0;
        din1 = '0;
        din2 = '0;
      end else if (scramble) begin
        din1 = 25'($urandom);
        din2 = 25'($urandom);
      end
    end
    if (!got) begin
      valid[w] = 1'b0;
      lat = -1;
    end
    @(posedge CLK);
    #1;
    busy_after = busy_w[w] | ack_w[w];
  endtask

  task automatic check_op(input string tag, input int w, input logic [24:0] a,
                          input logic [24:0] b, input bit scramble);
    int lat;
    logic [24:0] d;
    logic c, ba;
    logic [1:0] e;
    logic [27:0] exp;
    exp = ref_model(a, b);
    run_op(w, a, b, scramble, lat, d, c, e, ba);
    check({tag, " latency"}, 32'(lat), 32'(ref_latency(w, a)));
    check({tag, " dataout"}, 32'(d), 32'(exp[24:0]));
    check({tag, " carryout"}, 32'(c), 32'(exp[25]));
    check({tag, " exc"}, 32'(e), 32'(exp[27:26]));
    check({tag, " idle after ack"}, 32'(ba), 32'd0);
  endtask

  initial begin
    vec_t tbl [4];
    int lat;
    logic [24:0] d, prev_d;
    logic c, ba;
    logic [1:0] e;
    bit got;

    tbl[0] = '{a: 25'h0800000, b: 25'h0800000, exp_d: 25'h1000000, exp_c: 1'b0, exp_e: 2'b00};
    tbl[1] = '{a: 25'h0C00000, b: 25'h1C00000, exp_d: 25'h0800000, exp_c: 1'b1, exp_e: 2'b00};
    tbl[2] = '{a: 25'h0FFFFFF, b: 25'h1FFFFFF, exp_d: 25'h0FFFFFE, exp_c: 1'b1, exp_e: 2'b00};
    tbl[3] = '{a: 25'h1000001, b: 25'h0000005, exp_d: 25'h0000000, exp_c: 1'b0, exp_e: 2'b01};

    valid = 3'b000;
    din1  = '0;
    din2  = '0;
    RSTn  = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    for (int w = 0; w < 3; w++) begin
      check($sformatf("reset dataout w%0d", w), 32'(dout_w[w]), 32'd0);
      check($sformatf("reset carryout w%0d", w), 32'(cout_w[w]), 32'd0);
      check($sformatf("reset exc w%0d", w), 32'(exc_w[w]), 32'd0);
      check($sformatf("reset ack w%0d", w), 32'(ack_w[w]), 32'd0);
      check($sformatf("reset busy w%0d", w), 32'(busy_w[w]), 32'd0);
    end
    @(negedge CLK);
    RSTn = 1'b1;

    // Directed vectors at SEG_W=5
    for (int i = 0; i < 4; i++) begin
      run_op(0, tbl[i].a, tbl[i].b, 1'b0, lat, d, c, e, ba);
      check($sformatf("vec%0d latency", i), 32'(lat), tbl[i].a[24] ? 32'd1 : 32'd6);
      check($sformatf("vec%0d dataout", i), 32'(d), 32'(tbl[i].exp_d));
      check($sformatf("vec%0d carryout", i), 32'(c), 32'(tbl[i].exp_c));
      check($sformatf("vec%0d exc", i), 32'(e), 32'(tbl[i].exp_e));
      check($sformatf("vec%0d idle after ack", i), 32'(ba), 32'd0);
    end

    // Full ripple at SEG_W=1 and SEG_W=25
    run_op(1, tbl[2].a, tbl[2].b, 1'b1, lat, d, c, e, ba);
    check("ripple w1 latency", 32'(lat), 32'd26);
    check("ripple w1 dataout", 32'(d), 32'h0FFFFFE);
    check("ripple w1 carryout", 32'(c), 32'd1);
    run_op(2, tbl[2].a, tbl[2].b, 1'b1, lat, d, c, e, ba);
    check("ripple w25 latency", 32'(lat), 32'd2);
    check("ripple w25 dataout", 32'(d), 32'h0FFFFFE);
    check("ripple w25 carryout", 32'(c), 32'd1);

    // Abort after two ADD cycles: no ack, results untouched
    prev_d = dout_w[0];
    @(negedge CLK);
    din1 = 25'h0123456;
    din2 = 25'h0654321;
    valid[0] = 1'b1;
    got = 0;
    repeat (3) begin
      @(posedge CLK);
      #1;
      if (ack_w[0]) got = 1;
    end
    valid[0] = 1'b0;
    @(posedge CLK);
    #1;
    if (ack_w[0]) got = 1;
    check("abort busy", 32'(busy_w[0]), 32'd0);
    check("abort dataout held", 32'(dout_w[0]), 32'(prev_d));
    @(posedge CLK);
    #1;
    if (ack_w[0]) got = 1;
    check("abort no ack", 32'(got), 32'd0);
    check_op("after abort", 0, 25'h0123456, 25'h0654321, 1'b1);

    // Valid held past ack: WAIT_REL, no second ack
    @(negedge CLK);
    din1 = 25'h00ABCDE;
    din2 = 25'h0011111;
    valid[0] = 1'b1;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(posedge CLK);
      #1;
      if (ack_w[0]) got = 1;
    end
    check("waitrel first ack", 32'(got), 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(posedge CLK);
      #1;
      check($sformatf("waitrel no ack %0d", k), 32'(ack_w[0]), 32'd0);
      check($sformatf("waitrel busy %0d", k), 32'(busy_w[0]), 32'd1);
    end
    check("waitrel dataout", 32'(dout_w[0]), 32'h00BCDEF);
    valid[0] = 1'b0;
    @(posedge CLK);
    #1;
    check("waitrel release busy", 32'(busy_w[0]), 32'd0);

    // Reset during the third ADD cycle
    @(negedge CLK);
    din1 = 25'h0FEDCBA;
    din2 = 25'h0000777;
    valid[0] = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    RSTn = 1'b0;
    @(posedge CLK);
    #1;
    check("midreset dataout", 32'(dout_w[0]), 32'd0);
    check("midreset carryout", 32'(cout_w[0]), 32'd0);
    check("midreset exc", 32'(exc_w[0]), 32'd0);
    check("midreset ack", 32'(ack_w[0]), 32'd0);
    check("midreset busy", 32'(busy_w[0]), 32'd0);
    valid[0] = 1'b0;
    @(negedge CLK);
    RSTn = 1'b1;
    check_op("after reset", 0, 25'h0FEDCBA, 25'h0000777, 1'b0);

    // Randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      int w;
      logic [24:0] a, b;
      w = (i % 5 == 4) ? int'($urandom_range(1, 2)) : 0;
      a = 25'($urandom);
      b = 25'($urandom);
      if ($urandom_range(0, 7) != 0) a[24] = 1'b0;
      check_op($sformatf("rand%0d w%0d", i, w), w, a, b, 1'b1);
    end

    check("ack spacing", 32'(ack_double), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/adder_seg_unit.md
# adder_seg_unit

Segmented multi-cycle 25-bit adder that acts as the responder on the FPU adder-callee handshake (`Adder_valid` / `Adder_ack`). It accepts two 25-bit two's-complement mantissa operands from the adder controller and adds them `SEG_W` bits per cycle, LSB segment first. It returns a 25-bit sum, a carry-out and a 2-bit exception code with a single-cycle acknowledge. It replaces a single-cycle 25-bit carry chain on the FPU add path with a shorter per-cycle critical path.

## Interface
- `SEG_W`, default 5: bits added per cycle. Legal values are 1, 5 and 25. `N_SEG = 25/SEG_W`.
- `CLK`  in  1  clock, rising edge.
- `RSTn`  in  1  reset, synchronous, active-low.
- `Adder_valid`  in  1  request from the controller; held high until ack is seen.
- `Adder_datain1`  in  25  operand 1; bit 24 must be 0.
- `Adder_datain2`  in  25  operand 2, zero-extended or two's-complemented by the caller.
- `Adder_dataout`  out  25  sum[24:0].
- `Adder_carryout`  out  1  carry out of bit 24.
- `Adder_Exc`  out  2  00 = ok, 01 = illegal operand 1, 10/11 = reserved (never driven).
- `Adder_ack`  out  1  one-cycle pulse; dataout, carryout and Exc are valid in that cycle.
- `Busy`  out  1  high in any state other than IDLE.

## Operation
- **States:** IDLE, ADD, DONE, WAIT_REL. All outputs are registered.
- **Reset:** state = IDLE. `Adder_dataout` = 0, `Adder_carryout` = 0, `Adder_Exc` = 0, `Adder_ack` = 0, `Busy` = 0. Segment counter = 0, internal carry = 0.
- **IDLE:**
  - `Adder_valid` = 1 and `Adder_datain1[24]` = 0: latch both operands, clear counter and internal carry, go to ADD.
  - `Adder_valid` = 1 and `Adder_datain1[24]` = 1: load dataout = 0, carry = 0, Exc = 01, go to DONE. No add is performed.
- **ADD:** per cycle, for segment k = counter:
  - `{c, sum[k*SEG_W +: SEG_W]} = a[k] + b[k] + carry`; store c as the new internal carry; counter++.
  - After segment `N_SEG-1`: load `Adder_dataout`, `Adder_carryout` and Exc = 00, go to DONE.
  - Width rule: exact 26-bit result `{carryout, dataout} = datain1 + datain2`; no saturation.
- **DONE:** `Adder_ack` = 1 for exactly this cycle.
  - If `Adder_valid` = 0 in this cycle, go to IDLE; otherwise go to WAIT_REL.
- **WAIT_REL:** `Adder_ack` = 0. Stay until `Adder_valid` = 0, then go to IDLE. A still-high valid is never treated as a new request.
- **Abort:** `Adder_valid` = 0 in any ADD cycle → go to IDLE. No ack; result registers keep their previous values.
- **Result hold:** dataout, carryout and Exc hold from DONE until the next load (next DONE entry) or reset.
- **Operand sampling:** operands are sampled only at acceptance. Input changes while in ADD are ignored. The caller drives zero data after ack, so late re-sampling is forbidden.
- **Reset priority:** `RSTn` = 0 at any edge overrides every transition, including mid-ADD and DONE. Ack is never emitted for a request interrupted by reset.

## Timing
- **Legal-op latency:** edge E0 samples valid high in IDLE. ADD runs during cycles E0..E_N_SEG. Ack is high in the cycle following edge E_N_SEG, i.e. `N_SEG+1` cycles after valid is first high (6 cycles at `SEG_W` = 5, 2 cycles at `SEG_W` = 25).
- **Illegal-op latency:** ack is high 1 cycle after valid is first high.
- **Throughput:** one op per `N_SEG+2` cycles minimum, counting the DONE→IDLE re-entry.
- **Caller behaviour:** the controller samples ack at the same edge where it drops valid. Normal flow is therefore DONE → IDLE with no WAIT_REL cycle.
- **Ack spacing:** ack is never high in two consecutive cycles.

## Test plan
1. **Same-sign add.** `SEG_W` = 5, datain1 = 25'h0800000, datain2 = 25'h0800000 → ack in cycle 6, dataout = 25'h1000000, carryout = 0, Exc = 00.
2. **Subtraction via two's complement.** datain1 = 25'h0C00000, datain2 = 25'h1C00000 → dataout = 25'h0800000, carryout = 1, Exc = 00.
3. **Full carry ripple across all segments.** datain1 = 25'h0FFFFFF, datain2 = 25'h1FFFFFF → dataout = 25'h0FFFFFE, carryout = 1. Repeat at `SEG_W` = 1 and 25; the result is identical and ack arrives in cycles 26 and 2 respectively.
4. **Illegal operand.** datain1 = 25'h1000001 → ack in cycle 1, Exc = 01, dataout = 0, carryout = 0.
5. **Abort and WAIT_REL.**
   - Drop valid after 2 ADD cycles → no ack, `Busy` = 0 next cycle. A new request is then accepted and completes correctly.
   - Hold valid high 4 cycles past ack → state stays WAIT_REL with no second ack. Returns to IDLE the cycle after valid falls.
6. **Reset mid-operation.** Assert `RSTn` = 0 in ADD cycle 3 → all outputs 0 on the next cycle and no ack. A fresh op after release returns the correct sum.
